// File: rtl/dds_ctrl_if.sv
// ---------------------------------------------------------------------------
// dds_ctrl_if
// Bundles the soft-processor output-port bus with the three-wire DDS link.
//   port_id      : processor port address          (master -> slave)
//   out_port     : processor write data            (master -> slave)
//   write_strobe : one-cycle write qualifier       (master -> slave)
//   FSYNC        : frame sync to DDS, active low   (slave -> master)
//   SCLK         : serial clock to DDS, idles high (slave -> master)
//   SDATA        : serial data to DDS, MSB first   (slave -> master)
// ---------------------------------------------------------------------------
interface dds_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       FSYNC;
    logic       SCLK;
    logic       SDATA;

    modport master (
        output port_id, out_port, write_strobe,
        input  FSYNC, SCLK, SDATA
    );

    modport slave (
        input  port_id, out_port, write_strobe,
        output FSYNC, SCLK, SDATA
    );
endinterface

// File: rtl/dds_ctrl.sv
// ---------------------------------------------------------------------------
// dds_ctrl
// Captures 16-bit control words written over the processor output-port bus
// and shifts them MSB-first to an AD9833-class DDS on FSYNC/SCLK/SDATA.
// A single pending slot lets the processor submit a word while a frame is
// still in flight (last write wins).
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : dds_ctrl_if.slave (port_id/out_port/write_strobe in,
//         FSYNC/SCLK/SDATA out)
// Parameters: PORT_HI / PORT_LO port addresses, CLK_DIV = SCLK half-period
// in clk cycles (1..255).
// ---------------------------------------------------------------------------
module dds_ctrl #(
    parameter logic [7:0]  PORT_HI = 8'h10,
    parameter logic [7:0]  PORT_LO = 8'h11,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic      clk,
    input  logic      rst,
    dds_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  hi_q, hi_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_word_q, pend_word_d;
    logic        fsync_q, sclk_q, sdata_q;
    logic        fsync_d, sclk_d, sdata_d;

    logic        wr_hi, wr_lo, div_done;
    logic [15:0] sub_word;

    assign wr_hi    = bus.write_strobe && (bus.port_id == PORT_HI);
    assign wr_lo    = bus.write_strobe && (bus.port_id == PORT_LO);
    assign sub_word = {hi_q, bus.out_port};
    assign div_done = (div_q == 8'd0);

    assign bus.FSYNC = fsync_q;
    assign bus.SCLK  = sclk_q;
    assign bus.SDATA = sdata_q;

    // State register (pins are registered too, one cycle behind the state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hi_q        <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            fsync_q     <= 1'b1;
            sclk_q      <= 1'b1;
            sdata_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hi_q        <= hi_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            fsync_q     <= fsync_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hi_d        = hi_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;

        if (wr_hi) hi_d = bus.out_port;

        // A submitted word is parked by default; the IDLE/GAP branches below
        // clear the slot again when the word is launched in the same cycle.
        if (wr_lo) begin
            pend_d      = 1'b1;
            pend_word_d = sub_word;
        end

        if (!div_done) div_d = div_q - 8'd1;

        case (state_q)
            S_IDLE: begin
                if (wr_lo) begin
                    state_d = S_SETUP;
                    div_d   = DIV_LAST;
                    bit_d   = 4'd15;
                    shift_d = sub_word;
                    pend_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (div_done) begin
                    state_d = S_LOW;
                    div_d   = DIV_LAST;
                end
            end
            S_LOW: begin
                if (div_done) begin
                    state_d = S_HIGH;
                    div_d   = DIV_LAST;
                    // bit0 is held through the final HIGH (FSYNC hold time)
                    if (bit_q != 4'd0) shift_d = {shift_q[14:0], 1'b0};
                end
            end
            S_HIGH: begin
                if (div_done) begin
                    div_d = DIV_LAST;
                    if (bit_q == 4'd0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (div_done) begin
                    // A write landing in the last GAP cycle is newer than the
                    // pending word, so it wins and launches without delay.
                    if (wr_lo || pend_q) begin
                        state_d = S_SETUP;
                        div_d   = DIV_LAST;
                        bit_d   = 4'd15;
                        shift_d = wr_lo ? sub_word : pend_word_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, registered into the pin flops
    always_comb begin
        fsync_d = 1'b1;
        sclk_d  = 1'b1;
        sdata_d = 1'b0;
        case (state_q)
            S_SETUP, S_HIGH: begin
                fsync_d = 1'b0;
                sdata_d = shift_q[15];
            end
            S_LOW: begin
                fsync_d = 1'b0;
                sclk_d  = 1'b0;
                sdata_d = shift_q[15];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dds_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_ctrl
// Two instances (CLK_DIV=4 and CLK_DIV=1). A timing-level model predicts
// which words are framed and on which edge each frame starts; a monitor
// decodes the pins into frames and checks them against the queued
// predictions, plus pin-level rules (idle levels, SCLK high time, SDATA
// stability while SCLK is low).
// ---------------------------------------------------------------------------
module tb_dds_ctrl;
    localparam logic [7:0] P_HI = 8'h10;
    localparam logic [7:0] P_LO = 8'h11;
    localparam int D0 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_ctrl_if bus0();
    dds_ctrl_if bus1();

    dds_ctrl #(.PORT_HI(P_HI), .PORT_LO(P_LO), .CLK_DIV(D0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    dds_ctrl #(.PORT_HI(P_HI), .PORT_LO(P_LO), .CLK_DIV(D1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic [7:0] pid_a [2];
    logic [7:0] op_a  [2];
    logic       ws_a  [2];
    logic       fs [2];
    logic       sc [2];
    logic       sd [2];

    assign bus0.port_id      = pid_a[0];
    assign bus0.out_port     = op_a[0];
    assign bus0.write_strobe = ws_a[0];
    assign bus1.port_id      = pid_a[1];
    assign bus1.out_port     = op_a[1];
    assign bus1.write_strobe = ws_a[1];
    assign fs[0] = bus0.FSYNC;
    assign sc[0] = bus0.SCLK;
    assign sd[0] = bus0.SDATA;
    assign fs[1] = bus1.FSYNC;
    assign sc[1] = bus1.SCLK;
    assign sd[1] = bus1.SDATA;

    typedef struct {
        logic [15:0] word;
        int          start;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // Reference model state
    logic [7:0]  m_hi   [2] = '{8'h00, 8'h00};
    bit          m_pend [2] = '{1'b0, 1'b0};
    logic [15:0] m_pword[2] = '{16'h0, 16'h0};
    int          m_end  [2] = '{0, 0};

    // Monitor state
    bit          in_fr [2] = '{1'b0, 1'b0};
    bit          abort [2] = '{1'b0, 1'b0};
    int          nbits [2] = '{0, 0};
    int          lowlen[2] = '{0, 0};
    int          fallc [2] = '{0, 0};
    int          hicnt [2] = '{0, 0};
    logic [15:0] cap   [2] = '{16'h0, 16'h0};
    logic        psc   [2];
    logic        psd   [2];

    function automatic int dv(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %0h, expected %0h", nm, i, act, exp);
        end
    endtask

    task automatic m_start(input int i, input logic [15:0] w);
        frame_t f;
        f.word  = w;
        f.start = cyc;
        if (i == 0) q0.push_back(f);
        else        q1.push_back(f);
        m_end[i] = cyc + 34 * dv(i);
    endtask

    // One frame occupies 34*CLK_DIV edges from its start edge; writes before
    // that are parked (newest wins) and launched on the closing edge.
    task automatic model_step(input int i);
        logic [15:0] w;
        bit sub;
        if (rst) begin
            if (cyc < m_end[i] - dv(i) && qsize(i) > 0) begin
                if (i == 0) void'(q0.pop_back());
                else        void'(q1.pop_back());
            end
            m_hi[i]   = 8'h00;
            m_pend[i] = 1'b0;
            m_end[i]  = cyc;
        end else begin
            sub = ws_a[i] && (pid_a[i] == P_LO);
            w   = {m_hi[i], op_a[i]};
            if (ws_a[i] && (pid_a[i] == P_HI)) m_hi[i] = op_a[i];
            if (cyc >= m_end[i]) begin
                if (sub)            m_start(i, w);
                else if (m_pend[i]) m_start(i, m_pword[i]);
                m_pend[i] = 1'b0;
            end else if (sub) begin
                m_pend[i]  = 1'b1;
                m_pword[i] = w;
            end
        end
    endtask

    task automatic mon_step(input int i);
        frame_t e;
        if (fs[i]) begin
            chk(i, "idle_sclk", {31'd0, sc[i]}, 32'd1);
            chk(i, "idle_sdata", {31'd0, sd[i]}, 32'd0);
            if (in_fr[i]) begin
                in_fr[i] = 1'b0;
                if (!abort[i]) begin
                    if (qsize(i) == 0) begin
                        chk(i, "frame_expected", qsize(i), 32'd1);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk(i, "word", {16'd0, cap[i]}, {16'd0, e.word});
                        chk(i, "fall_count", nbits[i], 32'd16);
                        chk(i, "fsync_low_len", lowlen[i], 33 * dv(i));
                        chk(i, "fsync_fall_cycle", fallc[i], e.start + 2);
                    end
                end
            end
        end else begin
            if (!in_fr[i]) begin
                in_fr[i]  = 1'b1;
                abort[i]  = 1'b0;
                nbits[i]  = 0;
                cap[i]    = 16'h0;
                lowlen[i] = 0;
                fallc[i]  = cyc;
                hicnt[i]  = 0;
            end
            lowlen[i]++;
            if (rst) abort[i] = 1'b1;
            if (!sc[i] && psc[i]) begin
                cap[i] = {cap[i][14:0], sd[i]};
                nbits[i]++;
                if (!abort[i]) chk(i, "sclk_high_time", hicnt[i], dv(i));
                hicnt[i] = 0;
            end else if (sc[i]) begin
                hicnt[i]++;
            end else begin
                hicnt[i] = 0;
            end
            if (!sc[i] && !psc[i]) chk(i, "sdata_stable_low", {31'd0, sd[i]}, {31'd0, psd[i]});
        end
    endtask

    // Model runs on the active edge and also owns the edge counter.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
            cyc++;
        end
    end

    // Monitor samples on the opposite edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (armed) mon_step(i);
                psc[i] = sc[i];
                psd[i] = sd[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int i, input logic [7:0] p, input logic [7:0] d, input logic s);
        pid_a[i] = p;
        op_a[i]  = d;
        ws_a[i]  = s;
        @(posedge clk);
        #1;
        ws_a[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 3000; n++) begin
            if (!m_pend[i] && cyc > m_end[i] + 2) break;
            tick(1);
        end
    endtask

    initial begin
        int k;
        int sel;
        logic [7:0] p;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pid_a[i] = 8'h00;
            op_a[i]  = 8'h00;
            ws_a[i]  = 1'b0;
        end
        tick(3);
        rst   = 1'b0;
        armed = 1'b1;
        tick(50);

        // single word
        wr(0, P_HI, 8'h21, 1'b1);
        wr(0, P_LO, 8'h00, 1'b1);
        wait_idle(0);

        // back-to-back
        wr(0, P_HI, 8'h40, 1'b1);
        wr(0, P_LO, 8'h00, 1'b1);
        tick(40);
        wr(0, P_HI, 8'h5F, 1'b1);
        wr(0, P_LO, 8'hFF, 1'b1);
        wait_idle(0);

        // overwrite of the pending word
        wr(0, P_HI, 8'h40, 1'b1);
        wr(0, P_LO, 8'h00, 1'b1);
        tick(20);
        wr(0, P_HI, 8'h11, 1'b1);
        wr(0, P_LO, 8'h11, 1'b1);
        tick(10);
        wr(0, P_HI, 8'h22, 1'b1);
        wr(0, P_LO, 8'h22, 1'b1);
        wait_idle(0);

        // PORT_LO write in the last GAP cycle; PORT_HI mid-frame
        wr(0, P_HI, 8'h3C, 1'b1);
        wr(0, P_LO, 8'hA5, 1'b1);
        wr(0, P_HI, 8'h7E, 1'b1);
        for (int n = 0; n < 300 && cyc != m_end[0]; n++) tick(1);
        wr(0, P_LO, 8'h81, 1'b1);
        wait_idle(0);

        // reset at the 8th falling edge
        wr(0, P_HI, 8'h12, 1'b1);
        wr(0, P_LO, 8'h34, 1'b1);
        k = 0;
        while (k < 600 && !(in_fr[0] && nbits[0] == 8)) begin
            tick(1);
            k++;
        end
        if (k >= 600) chk(0, "wait_8th_fall", nbits[0], 32'd8);
        rst = 1'b1;
        tick(1);
        chk(0, "rst_fsync", {31'd0, fs[0]}, 32'd1);
        chk(0, "rst_sclk", {31'd0, sc[0]}, 32'd1);
        chk(0, "rst_sdata", {31'd0, sd[0]}, 32'd0);
        rst = 1'b0;
        tick(5);
        wr(0, P_LO, 8'h9A, 1'b1);
        wait_idle(0);

        // decode: ignored ports and unstrobed writes
        wr(0, P_HI, 8'h3D, 1'b1);
        wr(0, 8'h12, 8'h55, 1'b1);
        wr(0, 8'h00, 8'h66, 1'b1);
        wr(0, P_LO, 8'h77, 1'b0);
        wr(0, P_HI, 8'h99, 1'b0);
        tick(60);
        wr(0, P_LO, 8'h0F, 1'b1);
        wait_idle(0);

        // CLK_DIV=1 instance
        wr(1, P_HI, 8'hAA, 1'b1);
        wr(1, P_LO, 8'hAA, 1'b1);
        wait_idle(1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 1);
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1:    p = P_HI;
                2:       p = P_LO;
                3:       p = 8'h12;
                default: p = 8'($urandom);
            endcase
            wr(k, p, 8'($urandom), ($urandom_range(0, 7) != 0));
            if (sel == 2) tick($urandom_range(0, (k == 0) ? 90 : 40));
        end
        wait_idle(0);
        wait_idle(1);
        tick(10);

        chk(0, "leftover_frames", q0.size(), 32'd0);
        chk(1, "leftover_frames", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_ctrl.md
# dds_ctrl

Serial front-end for an AD9833-class DDS synthesizer. The block captures 16-bit control words written by the soft-processor over its 8-bit output-port bus and shifts each word MSB-first to the synthesizer on a three-wire FSYNC/SCLK/SDATA link. It sits between the processor I/O decode and the DDS chip pins. It has a one-word pending buffer so the processor can issue back-to-back words without polling.

## Interface
- PORT_HI, 8'h10: port_id that loads the high byte of the word.
- PORT_LO, 8'h11: port_id that loads the low byte of the word and requests transmission.
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.
- clk  in  1  system clock; all logic runs on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- port_id  in  8  processor port address.
- out_port  in  8  processor write data.
- write_strobe  in  1  one-cycle write qualifier; the write is valid only in cycles where it is high.
- FSYNC  out  1  frame sync to the DDS, active low.
- SCLK  out  1  serial clock to the DDS; idles high.
- SDATA  out  1  serial data to the DDS, MSB first.

## Operation
- Write decode:
  - write_strobe=1 with port_id=PORT_HI: hi_reg <= out_port.
  - write_strobe=1 with port_id=PORT_LO: word {hi_reg, out_port} is submitted.
  - All other port_id values are ignored.
  - hi_reg persists across words.
- Submission:
  - If the shifter is IDLE and no word is pending, the word starts immediately.
  - Otherwise the word goes into the single pending slot. A newer submission overwrites an older pending word (last write wins).
- A pending word starts when the shifter returns to IDLE.
- Shifter states and durations:
  - IDLE: FSYNC=1, SCLK=1, SDATA=0.
  - SETUP (CLK_DIV cycles): FSYNC=0, SCLK=1, SDATA=bit15.
  - LOW_n (CLK_DIV cycles): SCLK=0, SDATA holds bit n.
  - HIGH_n (CLK_DIV cycles): SCLK=1. On entry SDATA advances to bit n-1, except after bit0, where SDATA holds.
  - Sequence: SETUP, then LOW/HIGH pairs for bits 15..0. The HIGH after bit0 is the FSYNC hold time.
  - GAP (CLK_DIV cycles): FSYNC=1, SCLK=1, SDATA=0. Then IDLE, or directly SETUP if a word is pending.
- The DDS samples SDATA on SCLK falling edges. SDATA only changes while SCLK is high or idle.
- All outputs are driven from flip-flops, so there is no combinational path from inputs to pins.
- Counters:
  - Bit counter: 4 bits.
  - Divider counter: 8 bits, counts CLK_DIV-1 down to 0.
  - Shift register: 16 bits, shifts left.

## Timing
- Latency: a PORT_LO write sampled at edge k into IDLE gives FSYNC=0 and SDATA=bit15 after edge k+1.
- First SCLK falling edge: CLK_DIV cycles after FSYNC falls.
- FSYNC is low for 33·CLK_DIV cycles.
- Full word including GAP: 34·CLK_DIV cycles. With CLK_DIV=4 that is 132 cycles low and 136 total.
- Exactly 16 SCLK falling edges per frame, each CLK_DIV cycles after the preceding SCLK rise.
- Back-to-back: a pending word's FSYNC falls on the cycle after GAP completes. FSYNC stays high for exactly CLK_DIV cycles between frames.
- A PORT_LO write in the last GAP cycle is treated as pending and starts without extra delay.
- Reset:
  - rst=1 sampled at an edge forces IDLE outputs (FSYNC=1, SCLK=1, SDATA=0) after that edge.
  - Reset clears hi_reg, the shift register, the counters and the pending slot.
  - Reset mid-frame aborts the frame. No partial resume.
  - rst has priority over a simultaneous write_strobe.
- A PORT_HI write during a transfer does not affect the word being shifted.

## Test plan
- Reset: hold rst for 3 cycles, release -> FSYNC=1, SCLK=1, SDATA=0; no activity for 50 cycles.
- Single word, CLK_DIV=4: write 8'h21 to 8'h10, then 8'h00 to 8'h11.
  - FSYNC falls 1 cycle later and stays low 132 cycles.
  - 16 falling edges; bits captured at the falling edges equal 16'h2100.
  - FSYNC high 4 cycles before IDLE.
- Back-to-back: submit 16'h4000 then, mid-frame, 16'h5FFF -> second frame starts exactly 4 cycles after the first FSYNC rise and captures 16'h5FFF.
- Overwrite: during the frame for 16'h4000, submit 16'h1111 then 16'h2222 -> only 16'h4000 and 16'h2222 are transmitted.
- Reset mid-frame: assert rst at the 8th falling edge -> FSYNC=1 and SCLK=1 on the next cycle. A later word transmits intact.
- Decode: writes to port_id 8'h12 and 8'h00, and a PORT_LO value on out_port with write_strobe=0 -> no frame and hi_reg unchanged. CLK_DIV=1 run of 16'hAAAA -> FSYNC low 33 cycles and correct bits.
